// File: rtl/pseudo_linear_learner_pkg.sv
// ---------------------------------------------------------------------------
// pseudo_linear_learner_pkg
// Shared types and helpers for the pseudo-linear Boolean learner.
//   state_t     : learner FSM states (IDLE, COUNT, DECIDE, UPDATE)
//   DEF_*       : default parameter values for the learner top level
//   countWidth  : bits needed to hold a count from 0 to n inclusive
//   forward     : threshold decision y = ((numP >> shift) >= num)
// No ports (package).
// ---------------------------------------------------------------------------
package pseudo_linear_learner_pkg;

   localparam int DEF_N     = 784;
   localparam int DEF_CHUNK = 16;
   localparam int DEF_SHIFT = 2;
   localparam int DEF_ECW   = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_COUNT  = 2'd1,
      ST_DECIDE = 2'd2,
      ST_UPDATE = 2'd3
   } state_t;

   // Width of a counter that must represent every value 0..n, so that a
   // fully-set parameter vector still fits without wrapping.
   function automatic int countWidth(input int n);
      return $clog2(n + 1);
   endfunction

   // The classifier rule shared by the decision and by every trial flip:
   // the sample is "positive" when the matched-feature count does not exceed
   // the scaled-down size of the parameter vector.
   function automatic logic forward(input int unsigned num,
                                    input int unsigned numP,
                                    input int          shift);
      return (numP >> shift) >= num;
   endfunction

endpackage

// File: rtl/pseudo_linear_learner_chunk_popcount.sv
// ---------------------------------------------------------------------------
// pseudo_linear_learner_chunk_popcount
// Combinational population count of one CHUNK-wide slice.
//   i_bits  [W-1:0]            bits to count
//   o_count [CNTW-1:0]         number of ones in i_bits
// ---------------------------------------------------------------------------
module pseudo_linear_learner_chunk_popcount #(
   parameter  int W    = 16,
   localparam int CNTW = $clog2(W + 1)
) (
   input  logic [W-1:0]    i_bits,
   output logic [CNTW-1:0] o_count
);

   // Plain adder chain; W is small enough per chunk that the synthesis tool
   // can rebalance this into a tree without help.
   always_comb begin
      o_count = '0;
      for (int i = 0; i < W; i++) begin
         o_count = o_count + CNTW'(i_bits[i]);
      end
   end

endmodule

// File: rtl/pseudo_linear_learner.sv
// ---------------------------------------------------------------------------
// pseudo_linear_learner
// Multi-cycle pseudo-linear Boolean learner. Holds parameter vector p,
// classifies a sample x by y = ((popcount(p) >> SHIFT) >= popcount(p & x)),
// and on a trained error flips every bit of p whose single flip changes y.
// Popcounts are accumulated CHUNK bits per cycle.
//   clk          clock
//   rst_n        asynchronous active-low reset
//   i_train_en   update p on error (sampled at accept)
//   i_param_clr  synchronous clear of p and error count, aborts any operation
//   i_s_valid    sample valid
//   o_s_ready    sample can be accepted (IDLE only)
//   i_s_data     sample feature bits x[N-1:0]
//   i_s_label    ground-truth label
//   o_res_valid  one-cycle pulse qualifying o_res_out / o_res_err
//   o_res_out    prediction y
//   o_res_err    y ^ label
//   o_busy       FSM not in IDLE
//   o_err_count  saturating error count
//   o_param_out  current p
// ---------------------------------------------------------------------------
module pseudo_linear_learner
   import pseudo_linear_learner_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int CHUNK = DEF_CHUNK,
   parameter int SHIFT = DEF_SHIFT,
   parameter int ECW   = DEF_ECW
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_train_en,
   input  logic           i_param_clr,
   input  logic           i_s_valid,
   output logic           o_s_ready,
   input  logic [N-1:0]   i_s_data,
   input  logic           i_s_label,
   output logic           o_res_valid,
   output logic           o_res_out,
   output logic           o_res_err,
   output logic           o_busy,
   output logic [ECW-1:0] o_err_count,
   output logic [N-1:0]   o_param_out
);

   localparam int K  = N / CHUNK;
   localparam int KW = (K > 1) ? $clog2(K) : 1;
   localparam int CW = countWidth(N);
   localparam int PW = countWidth(CHUNK);
   localparam logic [KW-1:0] LAST_CHUNK = KW'(K - 1);

   // The chunk walk assumes every chunk is full; a ragged tail would silently
   // drop features, so refuse to elaborate instead.
   if (N % CHUNK != 0) begin : g_chunkCheck
      $error("pseudo_linear_learner: N must be a multiple of CHUNK");
   end

   state_t          r_state;
   logic [KW-1:0]   r_chunkIdx;
   logic [N-1:0]    r_param;
   logic [N-1:0]    r_sample;
   logic            r_label;
   logic            r_train;
   logic            r_y;
   logic [CW-1:0]   r_num;
   logic [CW-1:0]   r_numP;
   logic [ECW-1:0]  r_errCount;
   logic            r_resValid;
   logic            r_resOut;
   logic            r_resErr;

   logic            w_accept;
   logic            w_isLast;
   logic            w_y;
   logic [CHUNK-1:0] w_pChunk;
   logic [CHUNK-1:0] w_xChunk;
   logic [CHUNK-1:0] w_flip;
   logic [PW-1:0]   w_cntAnd;
   logic [PW-1:0]   w_cntP;
   logic [CW-1:0]   w_numR;
   logic [CW-1:0]   w_numPR;

   assign w_accept = i_s_valid & (r_state == ST_IDLE) & ~i_param_clr;
   assign w_isLast = (r_chunkIdx == LAST_CHUNK);
   assign w_pChunk = r_param[r_chunkIdx * CHUNK +: CHUNK];
   assign w_xChunk = r_sample[r_chunkIdx * CHUNK +: CHUNK];
   assign w_y      = forward(32'(r_num), 32'(r_numP), SHIFT);

   pseudo_linear_learner_chunk_popcount #(.W(CHUNK)) u_popAnd (
      .i_bits  (w_pChunk & w_xChunk),
      .o_count (w_cntAnd)
   );

   pseudo_linear_learner_chunk_popcount #(.W(CHUNK)) u_popParam (
      .i_bits  (w_pChunk),
      .o_count (w_cntP)
   );

   // Trial flip of each bit in the current chunk. Only the bit under test
   // moves the counts, so each trial is the frozen totals nudged by one.
   // The wrapped arms (num-1 with num=0, etc.) are never selected because a
   // decrement only happens when the bit being removed is actually present.
   always_comb begin
      w_flip  = '0;
      w_numR  = '0;
      w_numPR = '0;
      for (int j = 0; j < CHUNK; j++) begin
         w_numR = r_num;
         if (w_xChunk[j]) begin
            w_numR = w_pChunk[j] ? (r_num - CW'(1)) : (r_num + CW'(1));
         end
         w_numPR   = w_pChunk[j] ? (r_numP - CW'(1)) : (r_numP + CW'(1));
         w_flip[j] = r_y ^ forward(32'(w_numR), 32'(w_numPR), SHIFT);
      end
   end

   // Main FSM. Clear outranks everything but reset and kills any pending
   // result. COUNT accumulates both popcounts chunk by chunk, DECIDE emits the
   // result, UPDATE rewrites p one chunk at a time against the frozen counts
   // so every flip is judged on the pre-update vector.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_chunkIdx <= '0;
         r_param    <= '0;
         r_sample   <= '0;
         r_label    <= 1'b0;
         r_train    <= 1'b0;
         r_y        <= 1'b0;
         r_num      <= '0;
         r_numP     <= '0;
         r_errCount <= '0;
         r_resValid <= 1'b0;
         r_resOut   <= 1'b0;
         r_resErr   <= 1'b0;
      end else if (i_param_clr) begin
         r_state    <= ST_IDLE;
         r_chunkIdx <= '0;
         r_param    <= '0;
         r_errCount <= '0;
         r_resValid <= 1'b0;
         r_resOut   <= 1'b0;
         r_resErr   <= 1'b0;
      end else begin
         r_resValid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_sample   <= i_s_data;
                  r_label    <= i_s_label;
                  r_train    <= i_train_en;
                  r_num      <= '0;
                  r_numP     <= '0;
                  r_chunkIdx <= '0;
                  r_state    <= ST_COUNT;
               end
            end
            ST_COUNT: begin
               r_num  <= r_num + CW'(w_cntAnd);
               r_numP <= r_numP + CW'(w_cntP);
               if (w_isLast) begin
                  r_chunkIdx <= '0;
                  r_state    <= ST_DECIDE;
               end else begin
                  r_chunkIdx <= r_chunkIdx + KW'(1);
               end
            end
            ST_DECIDE: begin
               r_y        <= w_y;
               r_resValid <= 1'b1;
               r_resOut   <= w_y;
               r_resErr   <= w_y ^ r_label;
               r_chunkIdx <= '0;
               if ((w_y ^ r_label) && (r_errCount != '1)) begin
                  r_errCount <= r_errCount + ECW'(1);
               end
               if ((w_y ^ r_label) && r_train) begin
                  r_state <= ST_UPDATE;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_UPDATE: begin
               r_param[r_chunkIdx * CHUNK +: CHUNK] <= w_pChunk ^ w_flip;
               if (w_isLast) begin
                  r_chunkIdx <= '0;
                  r_state    <= ST_IDLE;
               end else begin
                  r_chunkIdx <= r_chunkIdx + KW'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_s_ready   = (r_state == ST_IDLE);
   assign o_busy      = (r_state != ST_IDLE);
   assign o_res_valid = r_resValid;
   assign o_res_out   = r_resOut;
   assign o_res_err   = r_resErr;
   assign o_err_count = r_errCount;
   assign o_param_out = r_param;

endmodule

// File: tb/tb_pseudo_linear_learner.sv
// ---------------------------------------------------------------------------
// tb_pseudo_linear_learner
// Self-checking bench for pseudo_linear_learner at N=16, CHUNK=4, SHIFT=2,
// ECW=4. A table of hand-derived transactions, directed reset/clear
// sequences, error-counter saturation and a randomized run against a
// popcount-level reference model.
// ---------------------------------------------------------------------------
module tb_pseudo_linear_learner;

   localparam int N     = 16;
   localparam int CHUNK = 4;
   localparam int SHIFT = 2;
   localparam int ECW   = 4;
   localparam int K     = N / CHUNK;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           i_train_en;
   logic           i_param_clr;
   logic           i_s_valid;
   logic           o_s_ready;
   logic [N-1:0]   i_s_data;
   logic           i_s_label;
   logic           o_res_valid;
   logic           o_res_out;
   logic           o_res_err;
   logic           o_busy;
   logic [ECW-1:0] o_err_count;
   logic [N-1:0]   o_param_out;

   int checkCount = 0;
   int passCount  = 0;

   typedef struct {
      logic [15:0] x;
      logic        lbl;
      logic        trn;
      logic        expOut;
      logic        expErr;
      logic [15:0] expP;
      logic [3:0]  expEc;
      int          expPeriod;
   } vec_t;

   typedef struct {
      logic [15:0] x;
      logic        lbl;
      logic        trn;
      int          cyc;
   } txn_t;

   vec_t vecs[10];
   txn_t pend[$];

   pseudo_linear_learner #(
      .N(N), .CHUNK(CHUNK), .SHIFT(SHIFT), .ECW(ECW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_train_en  (i_train_en),
      .i_param_clr (i_param_clr),
      .i_s_valid   (i_s_valid),
      .o_s_ready   (o_s_ready),
      .i_s_data    (i_s_data),
      .i_s_label   (i_s_label),
      .o_res_valid (o_res_valid),
      .o_res_out   (o_res_out),
      .o_res_err   (o_res_err),
      .o_busy      (o_busy),
      .o_err_count (o_err_count),
      .o_param_out (o_param_out)
   );

   // 10-unit clock period.
   always #5 clk = ~clk;

   // Hard stop in case some wait is never satisfied.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time exhausted");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checkCount++;
      if (actual === expected) passCount++;
      else $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference classifier straight from the popcount definition.
   function automatic logic refY(input logic [15:0] p, input logic [15:0] x);
      int np;
      int nm;
      np = $countones(p);
      nm = $countones(p & x);
      return (np >> SHIFT) >= nm;
   endfunction

   // Reference training step: literally try flipping each bit of the
   // original p and keep the flip if the decision would change.
   function automatic logic [15:0] refTrain(input logic [15:0] p, input logic [15:0] x);
      logic [15:0] q;
      logic [15:0] pf;
      logic        y;
      y = refY(p, x);
      q = p;
      for (int m = 0; m < N; m++) begin
         pf    = p;
         pf[m] = ~pf[m];
         if (refY(pf, x) != y) q[m] = ~p[m];
      end
      return q;
   endfunction

   // One full transaction: wait for ready, present the sample for one accept
   // edge, scramble the inputs, then report result latency and the earliest
   // edge at which the next sample could be accepted (both counted in edges
   // after the accept edge).
   task automatic applyStimulus(input logic [15:0] x, input logic lbl, input logic trn,
                                output int lat, output int period,
                                output logic rOut, output logic rErr);
      int n;
      lat = -1; period = -1; rOut = 1'b0; rErr = 1'b0;
      n = 0;
      while (!o_s_ready && n < 100) begin
         tick();
         n++;
      end
      checkOutput("ready_before_accept", 32'(o_s_ready), 32'd1);
      i_s_data = x; i_s_label = lbl; i_train_en = trn; i_s_valid = 1'b1;
      tick();
      i_s_valid = 1'b0; i_s_data = ~x; i_s_label = ~lbl; i_train_en = ~trn;
      n = 0;
      while (n < 60 && period < 0) begin
         tick();
         n++;
         if (o_res_valid && lat < 0) begin
            lat = n; rOut = o_res_out; rErr = o_res_err;
         end
         if (o_s_ready) period = n + 1;
      end
   endtask

   int          lat;
   int          period;
   logic        rOut;
   logic        rErr;
   int          nv;
   int          n;
   int          cyc;
   int          acceptN;
   int          orphanN;
   int          ovl;
   logic [15:0] modelP;
   logic [3:0]  modelEc;
   logic        expY;
   logic        expE;
   txn_t        t;

   initial begin
      vecs[0] = '{16'h00FF, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 4'd0, 6};
      vecs[1] = '{16'h0001, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0001, 4'd1, 10};
      vecs[2] = '{16'h0003, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 4'd1, 6};
      vecs[3] = '{16'h0002, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0001, 4'd1, 6};
      vecs[4] = '{16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 4'd2, 6};
      vecs[5] = '{16'h0001, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 4'd3, 10};
      vecs[6] = '{16'hF000, 1'b0, 1'b1, 1'b1, 1'b1, 16'hF000, 4'd4, 10};
      vecs[7] = '{16'hF00F, 1'b0, 1'b1, 1'b0, 1'b0, 16'hF000, 4'd4, 6};
      vecs[8] = '{16'h000F, 1'b0, 1'b1, 1'b1, 1'b1, 16'hF000, 4'd5, 10};
      vecs[9] = '{16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'hF000, 4'd5, 6};

      rst_n = 1'b0; i_train_en = 1'b0; i_param_clr = 1'b0;
      i_s_valid = 1'b0; i_s_data = '0; i_s_label = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_param", 32'(o_param_out), 32'h0);
      checkOutput("reset_errcount", 32'(o_err_count), 32'h0);
      checkOutput("reset_res_valid", 32'(o_res_valid), 32'h0);
      checkOutput("reset_ready", 32'(o_s_ready), 32'h1);
      checkOutput("reset_busy", 32'(o_busy), 32'h0);
      rst_n = 1'b1;
      tick();

      // Table of hand-derived transactions, run back to back from p=0.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].x, vecs[i].lbl, vecs[i].trn, lat, period, rOut, rErr);
         checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(K + 1));
         checkOutput($sformatf("vec%0d_out", i), 32'(rOut), 32'(vecs[i].expOut));
         checkOutput($sformatf("vec%0d_err", i), 32'(rErr), 32'(vecs[i].expErr));
         checkOutput($sformatf("vec%0d_param", i), 32'(o_param_out), 32'(vecs[i].expP));
         checkOutput($sformatf("vec%0d_errcount", i), 32'(o_err_count), 32'(vecs[i].expEc));
         checkOutput($sformatf("vec%0d_period", i), 32'(period), 32'(vecs[i].expPeriod));
      end

      // Asynchronous reset in the middle of COUNT with non-zero state.
      i_s_data = 16'h0F0F; i_s_label = 1'b1; i_train_en = 1'b1; i_s_valid = 1'b1;
      tick();
      i_s_valid = 1'b0;
      tick();
      checkOutput("busy_before_reset", 32'(o_busy), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midcount_reset_param", 32'(o_param_out), 32'h0);
      checkOutput("midcount_reset_errcount", 32'(o_err_count), 32'h0);
      checkOutput("midcount_reset_res_valid", 32'(o_res_valid), 32'h0);
      checkOutput("midcount_reset_ready", 32'(o_s_ready), 32'h1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      // Clear during UPDATE: first chunk already rewritten, then wiped.
      i_s_data = 16'h0001; i_s_label = 1'b0; i_train_en = 1'b1; i_s_valid = 1'b1;
      tick();
      i_s_valid = 1'b0;
      n = 0;
      while (!o_res_valid && n < 20) begin
         tick();
         n++;
      end
      checkOutput("upd_res_valid", 32'(o_res_valid), 32'h1);
      tick();
      checkOutput("mid_update_param", 32'(o_param_out), 32'h0001);
      checkOutput("mid_update_errcount", 32'(o_err_count), 32'h1);
      checkOutput("mid_update_busy", 32'(o_busy), 32'h1);
      i_param_clr = 1'b1;
      tick();
      i_param_clr = 1'b0;
      checkOutput("upd_clr_param", 32'(o_param_out), 32'h0);
      checkOutput("upd_clr_errcount", 32'(o_err_count), 32'h0);
      checkOutput("upd_clr_busy", 32'(o_busy), 32'h0);
      checkOutput("upd_clr_ready", 32'(o_s_ready), 32'h1);
      nv = 0;
      repeat (12) begin
         tick();
         if (o_res_valid) nv++;
      end
      checkOutput("upd_clr_no_res_valid", 32'(nv), 32'h0);

      // Clear exactly in the DECIDE cycle suppresses the result.
      i_s_data = 16'h0001; i_s_label = 1'b0; i_train_en = 1'b0; i_s_valid = 1'b1;
      tick();
      i_s_valid = 1'b0;
      repeat (K) tick();
      checkOutput("decide_busy", 32'(o_busy), 32'h1);
      i_param_clr = 1'b1;
      tick();
      i_param_clr = 1'b0;
      checkOutput("decide_clr_res_valid", 32'(o_res_valid), 32'h0);
      checkOutput("decide_clr_errcount", 32'(o_err_count), 32'h0);
      checkOutput("decide_clr_busy", 32'(o_busy), 32'h0);
      nv = 0;
      repeat (8) begin
         tick();
         if (o_res_valid) nv++;
      end
      checkOutput("decide_clr_no_res_valid", 32'(nv), 32'h0);

      // A sample offered together with clear must not be accepted.
      i_s_data = 16'h1234; i_s_valid = 1'b1; i_param_clr = 1'b1;
      tick();
      i_s_valid = 1'b0; i_param_clr = 1'b0;
      checkOutput("clr_blocks_accept", 32'(o_busy), 32'h0);
      tick();

      // 17 guaranteed errors (p=0 predicts 1, label 0): counter sticks at 15.
      for (int i = 0; i < 17; i++) begin
         applyStimulus(16'($urandom), 1'b0, 1'b0, lat, period, rOut, rErr);
         checkOutput($sformatf("sat%0d_err", i), 32'(rErr), 32'h1);
         if (i == 14) checkOutput("sat_reach_15", 32'(o_err_count), 32'hF);
      end
      checkOutput("sat_hold_15", 32'(o_err_count), 32'hF);
      checkOutput("sat_param_zero", 32'(o_param_out), 32'h0);

      // Randomized run with s_valid held high and data changing every cycle.
      i_param_clr = 1'b1;
      tick();
      i_param_clr = 1'b0;
      modelP = '0; modelEc = '0;
      cyc = 0; acceptN = 0; orphanN = 0; ovl = 0;
      i_s_valid = 1'b1;
      i_s_data = 16'($urandom); i_s_label = 1'($urandom); i_train_en = 1'b1;
      for (int it = 0; it < 430; it++) begin
         if (o_s_ready && i_s_valid) begin
            t.x = i_s_data; t.lbl = i_s_label; t.trn = i_train_en; t.cyc = cyc + 1;
            pend.push_back(t);
            acceptN++;
         end
         tick();
         cyc++;
         if (o_res_valid) begin
            if (pend.size() == 0) begin
               orphanN++;
            end else begin
               t = pend.pop_front();
               expY = refY(modelP, t.x);
               expE = expY ^ t.lbl;
               if (expE && modelEc != 4'hF) modelEc = modelEc + 4'd1;
               checkOutput("rnd_latency", 32'(cyc - t.cyc), 32'(K + 1));
               checkOutput("rnd_out", 32'(o_res_out), 32'(expY));
               checkOutput("rnd_err", 32'(o_res_err), 32'(expE));
               checkOutput("rnd_errcount", 32'(o_err_count), 32'(modelEc));
               if (expE && t.trn) modelP = refTrain(modelP, t.x);
            end
         end
         if (o_s_ready === o_busy) ovl++;
         if (o_s_ready) checkOutput("rnd_param_idle", 32'(o_param_out), 32'(modelP));
         i_s_valid  = (it < 400);
         i_s_data   = ($urandom_range(0, 1) == 1) ? 16'($urandom)
                                                  : 16'($urandom & $urandom & $urandom);
         i_s_label  = 1'($urandom);
         i_train_en = ($urandom_range(0, 3) != 0);
      end
      checkOutput("rnd_pending_empty", 32'(pend.size()), 32'h0);
      checkOutput("rnd_orphan_results", 32'(orphanN), 32'h0);
      checkOutput("rnd_ready_busy_overlap", 32'(ovl), 32'h0);
      checkOutput("rnd_enough_accepts", 32'(acceptN > 20), 32'h1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
